// File: rtl/demux_pkg.sv
// Shared definitions for the flow-controlled demultiplexer family:
// FSM state encoding and the drop counter geometry.
package demux_pkg;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_HOLD = 1'b1
    } flow_state_e;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/demux1xn_flow.sv
// 1-to-N demultiplexer with per-channel backpressure: a paused target parks the
// word in a one-entry hold register, out-of-range destinations are dropped and counted.
module demux1xn_flow
    import demux_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in,
    input  logic                     valid_in,
    input  logic [SEL_W-1:0]         classif,
    input  logic [NUM_CH-1:0]        pause,
    output logic                     ready_in,
    output logic [NUM_CH*DATA_W-1:0] out,
    output logic [NUM_CH-1:0]        push,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    flow_state_e            state;
    flow_state_e            state_nxt;
    logic                   ready_q;
    logic [DATA_W-1:0]      hold_data;
    logic [SEL_W-1:0]       hold_ch;
    logic                   cls_in_range;
    logic                   load_en;
    logic [SEL_W-1:0]       load_ch;
    logic [DATA_W-1:0]      load_data;
    logic                   hold_en;
    logic                   drop_en;
    logic [DROP_CNT_W-1:0]  drop_q;

    assign cls_in_range = ({1'b0, classif} < (SEL_W+1)'(NUM_CH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_PASS;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_PASS);
        end
    end

    // A word is only ever loaded into an output channel from here: either the
    // live input in PASS or the parked word once its channel un-pauses.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        load_ch   = hold_ch;
        load_data = hold_data;
        hold_en   = 1'b0;
        drop_en   = 1'b0;
        case (state)
            ST_PASS: begin
                if (valid_in) begin
                    if (!cls_in_range) begin
                        drop_en = 1'b1;
                    end else if (pause[classif]) begin
                        hold_en   = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        load_en   = 1'b1;
                        load_ch   = classif;
                        load_data = in;
                    end
                end
            end
            ST_HOLD: begin
                if (!pause[hold_ch]) begin
                    load_en   = 1'b1;
                    state_nxt = ST_PASS;
                end
            end
            default: state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data <= '0;
            hold_ch   <= '0;
        end else if (hold_en) begin
            hold_data <= in;
            hold_ch   <= classif;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (drop_en && (drop_q != DROP_CNT_MAX)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    // Each channel keeps its last pushed word; push is a one-cycle strobe.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic              sel;
        logic              push_r;
        logic [DATA_W-1:0] data_r;

        assign sel = load_en && (load_ch == SEL_W'(k));

        always_ff @(posedge clk) begin
            if (reset) begin
                push_r <= 1'b0;
                data_r <= '0;
            end else begin
                push_r <= sel;
                if (sel) begin
                    data_r <= load_data;
                end
            end
        end

        assign push[k]                   = push_r;
        assign out[k*DATA_W +: DATA_W]   = data_r;
    end

    assign ready_in = ready_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux1xn_flow.sv
// Self-checking bench: a 4-channel instance checked against a cycle model through a
// scoreboard queue, plus a 3-channel instance used for the out-of-range drop counter.
module tb_demux1xn_flow;

    localparam int DW  = 10;
    localparam int NCH = 4;
    localparam int SW  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                valid_in = 1'b0;
    logic [DW-1:0]       in = '0;
    logic [SW-1:0]       classif = '0;
    logic [NCH-1:0]      pause = '0;
    logic                ready_in;
    logic [NCH*DW-1:0]   out;
    logic [NCH-1:0]      push;
    logic [7:0]          drop_cnt;

    logic                valid3 = 1'b0;
    logic [DW-1:0]       in3 = '0;
    logic [1:0]          classif3 = '0;
    logic [2:0]          pause3 = '0;
    logic                ready3;
    logic [3*DW-1:0]     out3;
    logic [2:0]          push3;
    logic [7:0]          drop3;

    always #5 clk = ~clk;

    demux1xn_flow #(.DATA_W(DW), .NUM_CH(NCH)) dut (
        .clk(clk), .reset(reset), .in(in), .valid_in(valid_in), .classif(classif),
        .pause(pause), .ready_in(ready_in), .out(out), .push(push), .drop_cnt(drop_cnt)
    );

    demux1xn_flow #(.DATA_W(DW), .NUM_CH(3)) dut3 (
        .clk(clk), .reset(reset), .in(in3), .valid_in(valid3), .classif(classif3),
        .pause(pause3), .ready_in(ready3), .out(out3), .push(push3), .drop_cnt(drop3)
    );

    typedef struct {
        logic [NCH-1:0]    push;
        logic [NCH*DW-1:0] out;
        logic              ready;
        logic [7:0]        drop;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    logic              m_hold = 1'b0;
    logic [DW-1:0]     m_hd   = '0;
    logic [SW-1:0]     m_hc   = '0;
    logic [7:0]        m_drop = '0;
    logic [NCH*DW-1:0] m_out  = '0;
    logic [NCH-1:0]    m_push = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("push", 64'(push), 64'(e.push));
            check("out", 64'(out), 64'(e.out));
            check("ready_in", 64'(ready_in), 64'(e.ready));
            check("drop_cnt", 64'(drop_cnt), 64'(e.drop));
        end
    endtask

    // Predicts the outputs visible after the coming rising edge from the inputs just driven.
    task automatic modelStep();
        m_push = '0;
        if (reset) begin
            m_hold = 1'b0;
            m_hd   = '0;
            m_hc   = '0;
            m_drop = '0;
            m_out  = '0;
        end else if (!m_hold) begin
            if (valid_in) begin
                if (int'(classif) >= NCH) begin
                    if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
                end else if (pause[classif]) begin
                    m_hold = 1'b1;
                    m_hd   = in;
                    m_hc   = classif;
                end else begin
                    m_push[classif]        = 1'b1;
                    m_out[classif*DW +: DW] = in;
                end
            end
        end else if (!pause[m_hc]) begin
            m_push[m_hc]        = 1'b1;
            m_out[m_hc*DW +: DW] = m_hd;
            m_hold              = 1'b0;
        end
        sb.push_back('{m_push, m_out, !m_hold, m_drop});
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [SW-1:0] cls,
                                 input logic [DW-1:0] d, input logic [NCH-1:0] p);
        @(negedge clk);
        checkOutput();
        reset    = rst;
        valid_in = v;
        classif  = cls;
        in       = d;
        pause    = p;
        modelStep();
    endtask

    initial begin
        int bad3;
        logic [NCH-1:0] rp;

        // Reset with valid_in high: nothing may be accepted.
        applyStimulus(1'b1, 1'b1, 2'd1, 10'h111, 4'b0000);
        applyStimulus(1'b1, 1'b1, 2'd2, 10'h222, 4'b0000);

        // Routing to every channel back to back.
        for (int k = 0; k < NCH; k++) applyStimulus(1'b0, 1'b1, SW'(k), 10'h155, 4'b0000);
        applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b0000);

        // Stall on ch2; HOLD ignores new words and other channels' pause bits.
        applyStimulus(1'b0, 1'b1, 2'd2, 10'h2AA, 4'b0100);
        applyStimulus(1'b0, 1'b1, 2'd1, 10'h3FF, 4'b0100);
        applyStimulus(1'b0, 1'b1, 2'd1, 10'h3FE, 4'b0111);
        applyStimulus(1'b0, 1'b1, 2'd1, 10'h3FD, 4'b1110);
        applyStimulus(1'b0, 1'b1, 2'd1, 10'h3FC, 4'b0000);
        applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b0000);
        applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b0000);

        // A pause rising just after acceptance does not cancel the push.
        applyStimulus(1'b0, 1'b1, 2'd3, 10'h0C3, 4'b0000);
        applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b1000);
        applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b0000);

        // Reset while holding discards the parked word.
        applyStimulus(1'b0, 1'b1, 2'd0, 10'h0AB, 4'b0001);
        applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b0001);
        applyStimulus(1'b1, 1'b0, 2'd0, 10'h000, 4'b0000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b0000);

        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < NCH; b++) rp[b] = ($urandom_range(0, 3) == 0);
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), SW'($urandom_range(0, NCH-1)),
                          DW'($urandom_range(0, 1023)), rp);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b0000);
        applyStimulus(1'b0, 1'b0, 2'd0, 10'h000, 4'b0000);
        @(negedge clk);
        checkOutput();

        // Out-of-range destination on the 3-channel instance saturates the counter.
        bad3 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (push3 !== 3'b000) bad3++;
            if (i == 10)  check("drop3_after_10", 64'(drop3), 64'd10);
            if (i == 256) check("drop3_saturated", 64'(drop3), 64'd255);
            valid3   = 1'b1;
            classif3 = 2'd3;
            in3      = DW'(i);
        end
        @(negedge clk);
        valid3 = 1'b0;
        if (push3 !== 3'b000) bad3++;
        check("drop3_final", 64'(drop3), 64'd255);
        check("push3_never", 64'(bad3), 64'd0);
        check("ready3", 64'(ready3), 64'd1);
        check("out3_untouched", 64'(out3), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/demux1xn_flow.md
DEMUX1XN_FLOW -- requirements
Module: demux1xn_flow

Interface
REQ-001 The block SHALL have parameter DATA_W, default 10, giving the data word width.
REQ-002 The block SHALL have parameter NUM_CH, default 4, legal range 2..16, giving the output channel count.
REQ-003 The block SHALL have parameter SEL_W, default clog2(NUM_CH), giving the classif width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in, input, DATA_W bits: the input data word.
REQ-007 The block SHALL have port valid_in, input, 1 bit: in and classif are valid this cycle.
REQ-008 The block SHALL have port classif, input, SEL_W bits: the destination channel index.
REQ-009 The block SHALL have port pause, input, NUM_CH bits: per-channel downstream backpressure, where 1 means "do not push".
REQ-010 The block SHALL have port ready_in, output, 1 bit: the block accepts a word this cycle.
REQ-011 The block SHALL have port out, output, NUM_CH*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port push, output, NUM_CH bits: a one-hot or zero strobe marking a valid word on out channel k.
REQ-013 The block SHALL have port drop_cnt, output, 8 bits: a saturating count of dropped words.

Function
REQ-014 A word SHALL be accepted in a cycle where valid_in=1 and ready_in=1; it is never accepted otherwise.
REQ-015 An accepted word with classif<NUM_CH and pause[classif]=0 SHALL produce push[classif]=1 and out channel classif = in on the following cycle (latency 1).
REQ-016 At most one push bit SHALL be high in any cycle.
REQ-017 Out channels SHALL hold their last pushed value while their push bit is low.
REQ-018 The block SHALL implement a two-state FSM: PASS (ready_in=1) and HOLD (ready_in=0); ready_in SHALL be a registered function of state only.
REQ-019 PASS->HOLD: an accepted word whose target has pause=1 SHALL be stored in a one-entry hold register together with its channel index, with no push that cycle.
REQ-020 In HOLD, the block SHALL sample pause[held_ch] each cycle; when it reads 0, the block SHALL push the held word on the next cycle and return to PASS, so that ready_in=1 in that same next cycle.
REQ-021 In HOLD, valid_in, in and classif SHALL be ignored, and pause bits of other channels SHALL have no effect.
REQ-022 An accepted word with classif>=NUM_CH SHALL be dropped: no push, no state change, and drop_cnt incremented by 1, saturating at 255.
REQ-023 A pause change on the target channel during the cycle after acceptance SHALL NOT cancel a push already decided in REQ-015.

Reset
REQ-024 While reset=1, the block SHALL force state=PASS, push=0, all out channels=0, drop_cnt=0, and clear the hold register; ready_in SHALL read 1 from the first cycle after reset deasserts.
REQ-025 Reset asserted in HOLD SHALL discard the held word with no push and no drop_cnt increment.
REQ-026 While reset=1, valid_in SHALL be ignored.

Structure
REQ-027 The FSM state encoding and the drop_cnt width constant SHALL reside in the shared package demux_pkg; DATA_W and NUM_CH SHALL remain module parameters.
REQ-028 The block SHALL be a single module with no sub-modules; the per-channel output registers SHALL be generated by a generate loop.
REQ-029 The block SHALL be synthesizable to the cmos_cells library, and the synthesized netlist demux1xn_flow_syn SHALL match the behavioural model cycle-for-cycle.

Verification
REQ-030 Routing: NUM_CH=4, pause=0, send in=0x155 with classif=0..3 on consecutive cycles -> push=0001,0010,0100,1000 one cycle later each, out channel k=0x155, ready_in stays 1.
REQ-031 Stall: pause[2]=1, send 0x2AA to ch2 -> ready_in=0 next cycle, no push; drop pause[2] at cycle t -> push[2]=1 with 0x2AA at t+1, ready_in=1 at t+1.
REQ-032 Ignore-in-HOLD: during REQ-031 HOLD, drive valid_in=1 with classif=1 -> push[1] never asserted, the word is not counted.
REQ-033 Drop: NUM_CH=3, send classif=3 300 times -> no push ever, drop_cnt=255.
REQ-034 Reset mid-HOLD: enter HOLD, assert reset one cycle -> push=0, out=0, ready_in=1 after release, and the held word never appears.
REQ-035 Equivalence: 1000 random valid/classif/pause/in cycles applied to both behavioural and syn models -> all outputs identical every cycle.
